// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   Fetch stage in front of instruction_memory. It owns the PC, drives the
//   memory address combinationally and captures the returned word into the
//   IF/ID register. Unconditional jumps are pre-decoded here with no bubble.
//   A jump whose target is its own address freezes fetch (halt).
//
// Ports
//   i_clk              rising-edge clock
//   i_rst_n            synchronous active-low reset
//   i_stall            hold PC and IF/ID this cycle
//   i_redirect_valid   downstream branch/flush, overrides stall and halt
//   i_redirect_pc      target PC for a redirect
//   o_imem_addr        memory address, always equal to the current PC
//   i_imem_instr       instruction returned for o_imem_addr, same cycle
//   o_if_pc            PC of the instruction held in IF/ID
//   o_if_instr         instruction held in IF/ID
//   o_if_valid         IF/ID holds a real instruction (0 = bubble)
//   o_halted           self-jump fetched, fetch frozen
//   o_fetch_count      instructions captured with valid=1, saturating
//
// state   | meaning
// ST_RUN  | normal fetch; stall and pre-decode active
// ST_HALT | self-jump seen; PC frozen, bubbles issued until redirect/reset

module instruction_fetch_unit #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [5:0]  JUMP_OPCODE = 6'b010100,
  parameter int          COUNT_W     = 32
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_stall,
  input  logic               i_redirect_valid,
  input  logic [15:0]        i_redirect_pc,
  output logic [15:0]        o_imem_addr,
  input  logic [31:0]        i_imem_instr,
  output logic [15:0]        o_if_pc,
  output logic [31:0]        o_if_instr,
  output logic               o_if_valid,
  output logic               o_halted,
  output logic [COUNT_W-1:0] o_fetch_count
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t               r_state;
  logic [15:0]          r_pc;
  logic [15:0]          r_if_pc;
  logic [31:0]          r_if_instr;
  logic                 r_if_valid;
  logic [COUNT_W-1:0]   r_fetch_count;

  state_t               w_state_n;
  logic [15:0]          w_pc_n;
  logic [15:0]          w_if_pc_n;
  logic [31:0]          w_if_instr_n;
  logic                 w_if_valid_n;
  logic [COUNT_W-1:0]   w_fetch_count_n;

  logic                 w_is_jump;
  logic                 w_self_jump;
  logic                 w_count_max;

  assign w_is_jump   = (i_imem_instr[31:26] == JUMP_OPCODE);
  assign w_self_jump = w_is_jump && (i_imem_instr[15:0] == r_pc);
  assign w_count_max = &r_fetch_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= ST_RUN;
      r_pc          <= RESET_PC;
      r_if_pc       <= 16'h0000;
      r_if_instr    <= 32'h0000_0000;
      r_if_valid    <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      r_state       <= w_state_n;
      r_pc          <= w_pc_n;
      r_if_pc       <= w_if_pc_n;
      r_if_instr    <= w_if_instr_n;
      r_if_valid    <= w_if_valid_n;
      r_fetch_count <= w_fetch_count_n;
    end
  end

  always_comb begin
    w_state_n       = r_state;
    w_pc_n          = r_pc;
    w_if_pc_n       = r_if_pc;
    w_if_instr_n    = r_if_instr;
    w_if_valid_n    = r_if_valid;
    w_fetch_count_n = r_fetch_count;

    if (i_redirect_valid) begin
      // wrong-path word becomes a bubble; IF/ID payload is left as it was
      w_state_n    = ST_RUN;
      w_pc_n       = i_redirect_pc;
      w_if_valid_n = 1'b0;
    end else if (r_state == ST_HALT) begin
      w_if_valid_n = 1'b0;
    end else if (!i_stall) begin
      w_if_pc_n    = r_pc;
      w_if_instr_n = i_imem_instr;
      w_if_valid_n = 1'b1;
      if (!w_count_max) begin
        w_fetch_count_n = r_fetch_count + 1'b1;
      end
      if (w_self_jump) begin
        // the self-jump itself is delivered once, then fetch freezes
        w_state_n = ST_HALT;
        w_pc_n    = r_pc;
      end else if (w_is_jump) begin
        w_pc_n = i_imem_instr[15:0];
      end else begin
        w_pc_n = r_pc + 16'd1;
      end
    end
  end

  assign o_imem_addr   = r_pc;
  assign o_if_pc       = r_if_pc;
  assign o_if_instr    = r_if_instr;
  assign o_if_valid    = r_if_valid;
  assign o_halted      = (r_state == ST_HALT);
  assign o_fetch_count = r_fetch_count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a combinational memory model.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [15:0] imem_addr;
  logic [31:0] imem_instr;
  logic [15:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        halted;
  logic [31:0] fetch_count;

  logic [31:0] mem [0:65535];

  int n_checks = 0;
  int n_errors = 0;

  instruction_fetch_unit #(
    .RESET_PC    (16'h0000),
    .JUMP_OPCODE (6'b010100),
    .COUNT_W     (32)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_stall          (stall),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .o_imem_addr      (imem_addr),
    .i_imem_instr     (imem_instr),
    .o_if_pc          (if_pc),
    .o_if_instr       (if_instr),
    .o_if_valid       (if_valid),
    .o_halted         (halted),
    .o_fetch_count    (fetch_count)
  );

  assign imem_instr = mem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [15:0] e_addr,
                             input logic [15:0] e_if_pc, input logic [31:0] e_if_instr,
                             input logic e_valid, input logic e_halted,
                             input logic [31:0] e_count);
    check_eq({tag, ".addr"},   {16'h0, imem_addr}, {16'h0, e_addr});
    check_eq({tag, ".if_pc"},  {16'h0, if_pc},     {16'h0, e_if_pc});
    check_eq({tag, ".instr"},  if_instr,           e_if_instr);
    check_eq({tag, ".valid"},  {31'h0, if_valid},  {31'h0, e_valid});
    check_eq({tag, ".halted"}, {31'h0, halted},    {31'h0, e_halted});
    check_eq({tag, ".count"},  fetch_count,        e_count);
  endtask

  // one rising edge; returns at the following falling edge for sampling/driving
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic redirect(input logic [15:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 32'h0100_0000 | i;
    mem[2]  = 32'h3800_0001;  // conditional branch opcode 001110: not pre-decoded
    mem[17] = 32'h5000_0006;  // jump to 6
    mem[20] = 32'h5000_0014;  // jump to self

    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0;
    @(negedge clk);
    step();
    check_state("reset", 16'h0, 16'h0, 32'h0, 1'b0, 1'b0, 0);

    rst_n = 1'b1;
    step(); check_state("seq1", 16'd1, 16'd0, 32'h0100_0000, 1'b1, 1'b0, 1);
    step(); check_state("seq2", 16'd2, 16'd1, 32'h0100_0001, 1'b1, 1'b0, 2);
    step(); check_state("cbr",  16'd3, 16'd2, 32'h3800_0001, 1'b1, 1'b0, 3);

    redirect(16'd17);
    check_state("redir17", 16'd17, 16'd2, 32'h3800_0001, 1'b0, 1'b0, 3);
    step(); check_state("jump", 16'd6, 16'd17, 32'h5000_0006, 1'b1, 1'b0, 4);

    redirect(16'd20);
    check_state("redir20", 16'd20, 16'd17, 32'h5000_0006, 1'b0, 1'b0, 4);
    step(); check_state("selfjmp", 16'd20, 16'd20, 32'h5000_0014, 1'b1, 1'b1, 5);
    for (int i = 0; i < 10; i++) begin
      stall = i[0];
      step();
      check_state("halt", 16'd20, 16'd20, 32'h5000_0014, 1'b0, 1'b1, 5);
    end
    stall = 1'b0;
    redirect(16'd2);
    check_state("unhalt", 16'd2, 16'd20, 32'h5000_0014, 1'b0, 1'b0, 5);

    redirect(16'd4);
    step(); check_state("pc5", 16'd5, 16'd4, 32'h0100_0004, 1'b1, 1'b0, 6);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_state("stall", 16'd5, 16'd4, 32'h0100_0004, 1'b1, 1'b0, 6);
    end
    redirect(16'h0012);
    check_state("stall_redir", 16'h0012, 16'd4, 32'h0100_0004, 1'b0, 1'b0, 6);
    stall = 1'b0;
    step(); check_state("after_redir", 16'h0013, 16'h0012, 32'h0100_0012, 1'b1, 1'b0, 7);

    redirect(16'hFFFF);
    check_state("redirFFFF", 16'hFFFF, 16'h0012, 32'h0100_0012, 1'b0, 1'b0, 7);
    step(); check_state("wrap", 16'h0000, 16'hFFFF, 32'h0100_FFFF, 1'b1, 1'b0, 8);

    redirect(16'd20);
    step(); check_state("halt2", 16'd20, 16'd20, 32'h5000_0014, 1'b1, 1'b1, 9);
    stall = 1'b1;
    rst_n = 1'b0;
    step(); check_state("midreset", 16'h0, 16'h0, 32'h0, 1'b0, 1'b0, 0);
    stall = 1'b0;
    rst_n = 1'b1;
    step(); check_state("post_reset", 16'd1, 16'd0, 32'h0100_0000, 1'b1, 1'b0, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
